// File: rtl/fanout_fifo_nway.sv
// fanout_fifo_nway: replicates one token stream into NUM_OUT independently drained FIFO channels
module fanout_fifo_nway #(
  parameter int WIDTH_DATA   = 32,
  parameter int NUM_OUT      = 4,
  parameter int DEPTH_FIFO   = 16,
  parameter int THRESHOLD    = DEPTH_FIFO / 2,
  parameter int WIDTH_LENGTH = 8
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          I_Valid,
  input  logic [WIDTH_DATA-1:0]         I_Data,
  input  logic                          I_Last,
  output logic                          O_Nack,
  input  logic                          I_Mode,
  input  logic [NUM_OUT-1:0]            I_Mask,
  output logic [NUM_OUT-1:0]            O_Valid,
  output logic [NUM_OUT*WIDTH_DATA-1:0] O_Data,
  output logic [NUM_OUT-1:0]            O_Last,
  input  logic [NUM_OUT-1:0]            I_Nack,
  output logic [NUM_OUT-1:0]            O_Grt,
  output logic [WIDTH_LENGTH-1:0]       O_Len,
  output logic                          O_Busy
);
  localparam int AW = $clog2(DEPTH_FIFO);
  localparam logic [1:0] IDLE = 2'd0, RUN = 2'd1, DROP = 2'd2;
  logic [1:0] state;
  logic [NUM_OUT-1:0] grt, tgt, full;
  logic [WIDTH_LENGTH-1:0] cnt, len, cnt_inc;
  logic acc;
  assign tgt = state == IDLE ? (I_Mode ? I_Mask : '1) : grt;
  assign O_Nack = state != DROP && |(tgt & full);
  assign acc = I_Valid & ~O_Nack;
  assign cnt_inc = &cnt ? cnt : cnt + WIDTH_LENGTH'(1);
  assign O_Grt = grt;
  assign O_Len = len;
  assign O_Busy = state != IDLE || |O_Valid;
  // message sequencing: latch target on the header, count words, publish length on the last word
  always_ff @(posedge clock or negedge reset)
    if (!reset) begin
      state <= IDLE;
      grt <= '0;
      cnt <= '0;
      len <= '0;
    end else if (state == IDLE) begin
      grt <= acc ? tgt : '0;
      if (acc) begin
        cnt <= WIDTH_LENGTH'(1);
        if (I_Last) len <= WIDTH_LENGTH'(1);
        else state <= |tgt ? RUN : DROP;
      end
    end else if (acc) begin
      cnt <= cnt_inc;
      if (I_Last) begin
        len <= cnt_inc;
        grt <= '0;
        state <= IDLE;
      end
    end
  for (genvar k = 0; k < NUM_OUT; k++) begin : ch
    logic [WIDTH_DATA:0] mem [DEPTH_FIFO];
    logic [AW-1:0] wp, rp;
    logic [AW:0] occ;
    logic push, pop;
    assign push = acc & tgt[k];
    assign pop = O_Valid[k] & ~I_Nack[k];
    assign O_Valid[k] = occ != '0;
    assign full[k] = occ >= (AW+1)'(THRESHOLD);
    assign {O_Last[k], O_Data[k*WIDTH_DATA +: WIDTH_DATA]} = mem[rp];
    // storage is never reset; stale words are masked by an empty count
    always_ff @(posedge clock)
      if (push) mem[wp] <= {I_Last, I_Data};
    // pointers and occupancy; simultaneous push and pop leave the count unchanged
    always_ff @(posedge clock or negedge reset)
      if (!reset) begin
        wp <= '0;
        rp <= '0;
        occ <= '0;
      end else begin
        wp <= wp + AW'(push);
        rp <= rp + AW'(pop);
        occ <= occ + (AW+1)'(push) - (AW+1)'(pop);
      end
  end
endmodule

// File: tb/tb_fanout_fifo_nway.sv
// tb_fanout_fifo_nway: scoreboard bench for the fan-out FIFO
module tb_fanout_fifo_nway;
  logic clock = 0, reset = 0;
  logic I_Valid = 0, I_Last = 0, I_Mode = 0, O_Nack, O_Busy;
  logic [31:0] I_Data = 0;
  logic [3:0] I_Mask = 0, I_Nack = 0, O_Valid, O_Last, O_Grt;
  logic [127:0] O_Data;
  logic [7:0] O_Len;
  logic [32:0] q [4][$];
  int vectors = 0, errors = 0, grt_cyc = 0;
  logic [3:0] grt_val = 0;

  fanout_fifo_nway dut (
    .clock(clock), .reset(reset), .I_Valid(I_Valid), .I_Data(I_Data), .I_Last(I_Last),
    .O_Nack(O_Nack), .I_Mode(I_Mode), .I_Mask(I_Mask), .O_Valid(O_Valid), .O_Data(O_Data),
    .O_Last(O_Last), .I_Nack(I_Nack), .O_Grt(O_Grt), .O_Len(O_Len), .O_Busy(O_Busy)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  always @(negedge clock) if (reset) begin
    if (O_Grt != 0) begin
      grt_cyc++;
      grt_val = O_Grt;
    end
    for (int k = 0; k < 4; k++) if (O_Valid[k]) begin
      if (q[k].size() == 0) chk($sformatf("spurious_ch%0d", k), 1, 0);
      else begin
        chk($sformatf("ch%0d_word", k), {31'b0, O_Last[k], O_Data[k*32 +: 32]}, {31'b0, q[k][0]});
        if (!I_Nack[k]) void'(q[k].pop_front());
      end
    end
  end

  task automatic expect_word(input logic [31:0] d, input logic l, input logic [3:0] t);
    for (int k = 0; k < 4; k++) if (t[k]) q[k].push_back({l, d});
  endtask

  task automatic send(input logic [31:0] d, input logic l, input logic [3:0] t);
    int n = 0;
    I_Valid = 1;
    I_Data = d;
    I_Last = l;
    @(negedge clock);
    while (O_Nack && n < 300) begin
      @(negedge clock);
      n++;
    end
    if (O_Nack) chk("accept_timeout", 1, 0);
    else expect_word(d, l, t);
    @(posedge clock);
    #1 I_Valid = 0;
    I_Last = 0;
  endtask

  task automatic msg(input int n, input logic [31:0] base, input logic mode, input logic [3:0] mask);
    logic [3:0] t;
    t = mode ? mask : 4'hf;
    I_Mode = mode;
    I_Mask = mask;
    grt_cyc = 0;
    grt_val = 0;
    for (int i = 0; i < n; i++) send(base + i, i == n - 1, t);
  endtask

  task automatic wait_idle;
    int n = 0;
    while ((O_Busy || q[0].size() + q[1].size() + q[2].size() + q[3].size() != 0) && n < 500) begin
      @(posedge clock);
      n++;
    end
    #1 chk("drain_timeout", n < 500, 1);
  endtask

  initial begin
    int acc;
    repeat (2) @(posedge clock);
    #1 chk("rst_valid", O_Valid, 0);
    chk("rst_nack", O_Nack, 0);
    chk("rst_busy", O_Busy, 0);
    chk("rst_grt", O_Grt, 0);
    chk("rst_len", O_Len, 0);
    reset = 1;
    @(posedge clock);
    #1;
    msg(3, 32'hA, 0, 0);
    wait_idle();
    chk("bc_len", O_Len, 3);
    chk("bc_grt_cycles", grt_cyc, 2);
    chk("bc_grt", grt_val, 4'hf);
    msg(2, 32'h20, 1, 4'b0101);
    wait_idle();
    chk("rt_grt", grt_val, 4'b0101);
    chk("rt_grt_cycles", grt_cyc, 1);
    chk("rt_len", O_Len, 2);
    I_Mode = 0;
    I_Nack = 4'b0010;
    acc = 0;
    I_Valid = 1;
    I_Data = 32'h100;
    I_Last = 0;
    for (int c = 0; c < 30; c++) begin
      @(negedge clock);
      if (!O_Nack) begin
        expect_word(I_Data, I_Last, 4'hf);
        acc++;
      end
      @(posedge clock);
      #1 I_Data = 32'h100 + acc;
    end
    chk("bp_accepted", acc, 8);
    chk("bp_nack", O_Nack, 1);
    I_Nack = 0;
    for (int i = acc; i < 20; i++) send(32'h100 + i, i == 19, 4'hf);
    wait_idle();
    chk("bp_len", O_Len, 20);
    msg(4, 32'h200, 1, 4'b0000);
    wait_idle();
    chk("drop_len", O_Len, 4);
    chk("drop_grt_cycles", grt_cyc, 0);
    msg(2, 32'h300, 0, 0);
    wait_idle();
    chk("after_drop_len", O_Len, 2);
    msg(1, 32'h400, 1, 4'b0010);
    wait_idle();
    chk("unit_grt", grt_val, 4'b0010);
    chk("unit_grt_cycles", grt_cyc, 1);
    chk("unit_len", O_Len, 1);
    I_Nack = 4'b1000;
    I_Mode = 0;
    send(32'h500, 0, 4'hf);
    send(32'h501, 0, 4'hf);
    repeat (3) @(posedge clock);
    #1 reset = 0;
    #1 chk("mid_rst_valid", O_Valid, 0);
    chk("mid_rst_busy", O_Busy, 0);
    chk("mid_rst_grt", O_Grt, 0);
    for (int k = 0; k < 4; k++) q[k].delete();
    repeat (2) @(posedge clock);
    #1 reset = 1;
    I_Nack = 0;
    msg(1, 32'h600, 0, 0);
    wait_idle();
    chk("post_rst_len", O_Len, 1);
    chk("post_rst_grt_cycles", grt_cyc, 1);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule

// File: doc/fanout_fifo_nway.md
Name: fanout_fifo_nway

Overview:
- Parametrised successor to the two-way FanOut link element.
- Accepts one forward token stream and replicates each message into NUM_OUT independently buffered output channels.
- Two modes: broadcast (all channels) or routed (per-message channel mask sampled on the header word).
- Each output drains at its own rate. A grant vector reports which channels the in-flight message targets.

Parameters:
- WIDTH_DATA, 32: data word width.
- NUM_OUT, 4: number of output channels (2..8).
- DEPTH_FIFO, 16: per-channel FIFO depth. Must be a power of two, >= 4.
- THRESHOLD, DEPTH_FIFO/2: occupancy at or above which the input is back-pressured. Range 1..DEPTH_FIFO.
- WIDTH_LENGTH, 8: width of the message word counter.

Ports:
- clock  in  1  — system clock. Single clock domain.
- reset  in  1  — asynchronous, active-low reset.
- I_Valid  in  1  — input word valid.
- I_Data  in  WIDTH_DATA  — input word.
- I_Last  in  1  — last word of message.
- O_Nack  out  1  — input back-pressure. A word transfers only when I_Valid & ~O_Nack.
- I_Mode  in  1  — 0 = broadcast, 1 = routed. Sampled on the header word.
- I_Mask  in  NUM_OUT  — target channel mask. Sampled on the header word when I_Mode = 1.
- O_Valid  out  NUM_OUT  — per-channel output valid.
- O_Data  out  NUM_OUT*WIDTH_DATA  — per-channel output word. Channel k occupies bits [k*WIDTH_DATA +: WIDTH_DATA].
- O_Last  out  NUM_OUT  — per-channel last flag.
- I_Nack  in  NUM_OUT  — per-channel downstream back-pressure.
- O_Grt  out  NUM_OUT  — grant: latched mask of the in-flight message.
- O_Len  out  WIDTH_LENGTH  — word count of the most recently completed input message.
- O_Busy  out  1  — high while any FIFO is non-empty or state is not IDLE.

Behaviour:
- Reset (reset = 0, asynchronous):
  - State -> IDLE; all FIFO pointers and counts cleared; contents discarded.
  - O_Valid, O_Last, O_Grt, O_Len, O_Busy = 0. O_Nack = 0.
  - Reset mid-message drops the message silently.
- Target mask T:
  - IDLE: T = all-ones when I_Mode = 0, else I_Mask.
  - RUN / DROP: T = the latched grant register G.
- Back-pressure: O_Nack = OR over k in T of (count[k] >= THRESHOLD). Combinational from registered counts.
  - Exception: in DROP, O_Nack = 0.
- Push: an accepted word (I_Valid & ~O_Nack) is written, with its I_Last, to every FIFO k with T[k] = 1.
  - count[k] updates on the next edge.
  - Overflow is impossible because THRESHOLD <= DEPTH_FIFO.
- Pop: channel k pops when O_Valid[k] & ~I_Nack[k].
  - O_Valid[k] = (count[k] != 0). Head word is presented combinationally from the FIFO RAM (registered read pointer).
  - Simultaneous push and pop on one channel: count unchanged. Pop on empty never occurs.
- FSM:
  - IDLE, accepted header word with T != 0:
    - Not last: G <= T, state -> RUN, word counter <= 1.
    - Last (unit-length message): G <= T for one cycle, stays IDLE, O_Len <= 1 next cycle.
  - IDLE, accepted header word with T == 0:
    - Not last: state -> DROP, G <= 0, counter <= 1.
    - Last: O_Len <= 1, stays IDLE. Word discarded.
  - RUN: each accepted word increments the counter (saturating at all-ones). On an accepted I_Last word: O_Len <= counter+1 (saturating), G <= 0, state -> IDLE.
  - DROP: words are consumed (O_Nack = 0) and discarded. On I_Last: O_Len <= counter+1 (saturating), state -> IDLE.
  - I_Mode / I_Mask changes outside IDLE are ignored.
- O_Grt = G, registered. It rises the cycle after the header is accepted and falls the cycle after the last word is accepted.
- Latency: an accepted word appears on O_Valid[k] one cycle later.
- A new message may be accepted in IDLE the cycle after a prior last word, even while FIFOs still drain.
- Ordering: per-channel order is preserved. Channels are mutually independent: a stalled channel back-pressures the input only when it is in T.

Test Plan:
- Broadcast, NUM_OUT=4: 3-word message 0xA,0xB,0xC with I_Nack = 0.
  - All four channels emit A,B,C on cycles 1..3 after each word is accepted; O_Last only with C.
  - O_Grt = 4'b1111 for 2 cycles; O_Len = 3.
- Routed, I_Mask = 4'b0101, 2 words.
  - Only channels 0 and 2 emit; channels 1 and 3 show O_Valid = 0 throughout.
  - O_Grt = 4'b0101.
- Back-pressure, DEPTH=16, THRESHOLD=8, broadcast: hold I_Nack[1] = 1, stream 20 words continuously.
  - O_Nack asserts once count[1] = 8; exactly 8 words are accepted.
  - Release I_Nack[1]: all 20 words eventually delivered in order to all channels.
- Routed, mask 4'b0000, 4-word message.
  - O_Nack = 0, all words consumed, no O_Valid; O_Len = 4; then a following broadcast message is delivered normally.
- Unit-length message, I_Last on header, mask 4'b0010.
  - O_Grt = 4'b0010 for exactly one cycle; channel 1 emits one word with O_Last = 1; O_Len = 1.
- Reset asserted mid-message after 2 of 5 words, with channel 3 stalled.
  - Immediately all O_Valid = 0, O_Busy = 0, O_Grt = 0.
  - After release, a new 1-word broadcast is delivered on all channels.
